rowload_ctrl_mdl: RTL and testbench
===================================

Name: rowload_ctrl_mdl

Overview:
Sequencer that fills the matrix row buffer. On a start pulse it fetches N 1024-bit beats from row memory and pushes each beat into the row buffer (enable + data). It then issues the end strobe, waits for the buffer's set flag, and hands the completed row to the matrix stage over a valid/ready handshake. It sits between the row memory port and the row buffer, which it drives and observes.

Parameters:
DAT_W, 1024, beat width; must match the row buffer input width.
ADDR_W, 16, row memory address width.
MAX_BEATS, 8, maximum beats per row.
TO_CYC, 255, memAck watchdog limit in cycles; used only with the optional feature.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request to load one row; sampled only in IDLE.
baseAddr  in  ADDR_W  first beat address; latched on an accepted start.
beatNum  in  4  beats to load; latched on an accepted start.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a row handoff completes.
errFlag  out  1  sticky memory-timeout error; optional feature only, otherwise tied 0.
memReq  out  1  row memory read request.
memAddr  out  ADDR_W  row memory read address.
memAck  in  1  read acknowledge; memDat is valid in the same cycle.
memDat  in  DAT_W  read data.
bufEnable  out  1  row buffer enable.
bufDendFlag  out  1  row buffer end strobe.
bufDats  out  DAT_W  beat data to the row buffer.
bufDsetFlag  in  1  row buffer output-valid flag.
rowValid  out  1  completed row available to the matrix stage.
rowReady  in  1  matrix stage accepts the row.

Behaviour:
- Reset (async, high): state IDLE, beat index 0. memReq, bufEnable, bufDendFlag, rowValid, busy, done, errFlag all 0. memAddr 0, bufDats 0.
- Latch on an accepted start: beatCnt = beatNum. beatNum 0 or greater than MAX_BEATS is clamped to MAX_BEATS.
- start outside IDLE is ignored; no queueing.
- IDLE: on start, go to REQ.
- REQ:
  - memReq=1 and memAddr=baseAddr+idx, both held steady until memAck.
  - Address addition wraps modulo 2^ADDR_W.
  - On memAck, register memDat into bufDats, drop memReq on the next cycle, go to PUSH.
- PUSH (exactly one cycle):
  - bufEnable=1, bufDendFlag=0, idx increments.
  - If idx+1 == beatCnt, go to ENDS; else go to REQ.
  - Minimum cost is 2 cycles per beat.
- ENDS (exactly one cycle): bufEnable=1, bufDendFlag=1, go to WSET.
- WSET:
  - bufEnable=0; wait for bufDsetFlag=1, then go to HAND.
  - bufDsetFlag already high on entry moves to HAND on the next edge.
- HAND:
  - rowValid=1, held until rowReady.
  - The cycle where rowValid&&rowReady is the transfer. Next cycle: rowValid=0, done=1 for one cycle, idx=0, state IDLE.
  - rowReady outside HAND has no effect.
- bufEnable and bufDendFlag are never high outside PUSH/ENDS.
- busy is combinational from state (state!=IDLE).
- Latency for N beats with zero-wait memAck and immediate bufDsetFlag/rowReady: start to done = 2N+4 cycles.
- Reset mid-operation aborts immediately with no end strobe issued. The row buffer is expected to share the system reset.

Optional Feature:
ROWCTRL_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog counts cycles in REQ without memAck.
  - Reaching TO_CYC sets errFlag (sticky until reset), drops memReq and goes to ENDS, so the partial row is flushed. Handoff then proceeds normally.
  - The counter clears on every memAck and every REQ entry.
- Undefined: no watchdog, REQ waits indefinitely, errFlag tied to 0.

Test Plan:
- Reset, then start with baseAddr=0x0010, beatNum=3, memAck same cycle as each request -> memAddr 0x0010,0x0011,0x0012; three bufEnable pulses with data D0..D2; one bufDendFlag; with immediate bufDsetFlag and rowReady, done at cycle 10 after start.
- beatNum=0 and beatNum=12 -> exactly 8 memReq transactions each, then one end strobe.
- baseAddr=0xFFFE, beatNum=4 -> memAddr 0xFFFE,0xFFFF,0x0000,0x0001.
- memAck delayed 5 cycles per beat and rowReady held low 7 cycles in HAND -> memReq/memAddr stable while waiting; rowValid stays high for 8 cycles; a start pulse mid-run is ignored.
- Assert reset while in REQ with beat 2 of 5 -> all outputs 0 asynchronously; a new start after release loads from idx 0.
- With ROWCTRL_TIMEOUT_EN, TO_CYC=20, memAck never returned on beat 1 -> memReq drops after 20 cycles, errFlag=1, bufDendFlag pulse, handoff completes, errFlag stays high until reset.

Source files
------------

// File: rtl/rowload_ctrl_mdl_if.sv
// rtl/rowload_ctrl_mdl_if.sv - row memory, row buffer and matrix handoff signals of the row loader
interface rowload_ctrl_mdl_if #(
  parameter int DAT_W  = 1024,
  parameter int ADDR_W = 16
);
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [DAT_W-1:0]  memDat;
  logic              bufEnable;
  logic              bufDendFlag;
  logic [DAT_W-1:0]  bufDats;
  logic              bufDsetFlag;
  logic              rowValid;
  logic              rowReady;

  modport master (
    output memReq, memAddr, bufEnable, bufDendFlag, bufDats, rowValid,
    input  memAck, memDat, bufDsetFlag, rowReady
  );

  modport slave (
    input  memReq, memAddr, bufEnable, bufDendFlag, bufDats, rowValid,
    output memAck, memDat, bufDsetFlag, rowReady
  );
endinterface

// File: rtl/rowload_ctrl_mdl.sv
// rtl/rowload_ctrl_mdl.sv - row buffer fill sequencer (memory fetch, push, end strobe, row handoff)
// Optional memAck watchdog with sticky errFlag enabled by ROWCTRL_TIMEOUT_EN.
module rowload_ctrl_mdl #(
  parameter int DAT_W     = 1024,
  parameter int ADDR_W    = 16,
  parameter int MAX_BEATS = 8,
  parameter int TO_CYC    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [3:0]        beatNum,
  output logic              busy,
  output logic              done,
  output logic              errFlag,
  rowload_ctrl_mdl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PUSH, S_ENDS, S_WSET, S_HAND
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BEATS);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        beatcnt_q, beatcnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DAT_W-1:0]  dats_q, dats_d;
  logic              done_q, done_d;
  logic              timeout;

`ifdef ROWCTRL_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;

  // Watchdog only runs while a request is outstanding; any other state clears it.
  always_comb begin
    wd_d    = 8'd0;
    timeout = 1'b0;
    err_d   = err_q;
    if (state_q == S_REQ && !bus.memAck) begin
      wd_d    = wd_q + 8'd1;
      timeout = (wd_d == TO_CYC[7:0]);
    end
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign errFlag = err_q;
`else
  logic [7:0] to_cyc_unused;
  assign to_cyc_unused = TO_CYC[7:0];
  assign timeout       = 1'b0;
  assign errFlag       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    beatcnt_d = beatcnt_q;
    base_d    = base_q;
    dats_d    = dats_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = baseAddr;
          beatcnt_d = (beatNum == 4'd0 || beatNum > MAX_B) ? MAX_B : beatNum;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.memAck) begin
          dats_d  = bus.memDat;
          state_d = S_PUSH;
        end else if (timeout) begin
          state_d = S_ENDS;
        end
      end
      S_PUSH: begin
        idx_d   = idx_q + 4'd1;
        state_d = (idx_q + 4'd1 == beatcnt_q) ? S_ENDS : S_REQ;
      end
      S_ENDS: state_d = S_WSET;
      S_WSET: begin
        if (bus.bufDsetFlag) state_d = S_HAND;
      end
      S_HAND: begin
        if (bus.rowReady) begin
          idx_d   = 4'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      beatcnt_q <= 4'd0;
      base_q    <= '0;
      dats_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      beatcnt_q <= beatcnt_d;
      base_q    <= base_d;
      dats_q    <= dats_d;
      done_q    <= done_d;
    end
  end

  // Outputs decode straight from the state so a reset clears them without waiting for a clock.
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign bus.memReq      = (state_q == S_REQ);
  assign bus.memAddr     = (state_q == S_REQ) ? base_q + ADDR_W'(idx_q) : '0;
  assign bus.bufEnable   = (state_q == S_PUSH) || (state_q == S_ENDS);
  assign bus.bufDendFlag = (state_q == S_ENDS);
  assign bus.bufDats     = dats_q;
  assign bus.rowValid    = (state_q == S_HAND);
endmodule

// File: tb/tb_rowload_ctrl_mdl.sv
// tb/tb_rowload_ctrl_mdl.sv - scoreboard bench for rowload_ctrl_mdl
`timescale 1ns/1ps
module tb_rowload_ctrl_mdl;
  localparam int DW = 1024;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [3:0]    beatNum = 4'd0;
  logic          busy, done, errFlag;

  rowload_ctrl_mdl_if #(.DAT_W(DW), .ADDR_W(AW)) bus();

  rowload_ctrl_mdl #(.DAT_W(DW), .ADDR_W(AW), .MAX_BEATS(8), .TO_CYC(20)) dut (
    .clock(clk), .reset(rst), .start(start), .baseAddr(baseAddr), .beatNum(beatNum),
    .busy(busy), .done(done), .errFlag(errFlag), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] dat_q[$];
  int ack_dly, rdy_dly, hang_beat;
  int wait_cnt, rv_cnt, acks_row, req_cycles, ends_cnt, valid_cycles, done_cnt;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {64{a ^ 16'hA5C3}};
  endfunction

  // One cycle at the falling edge: memory/matrix responders plus scoreboard checks.
  task automatic tick();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    if (bus.memReq) begin
      req_cycles++;
      if (acks_row != hang_beat && wait_cnt >= ack_dly) begin
        bus.memAck = 1'b1;
        bus.memDat = pat(bus.memAddr);
      end else begin
        bus.memAck = 1'b0;
      end
      wait_cnt++;
    end else begin
      bus.memAck = 1'b0;
      wait_cnt   = 0;
    end
    if (bus.memReq && bus.memAck) begin
      total++;
      acks_row++;
      if (addr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_req: got addr %h want no request", bus.memAddr);
      end else begin
        ea = addr_q.pop_front();
        dat_q.push_back(pat(ea));
        if (bus.memAddr !== ea) begin
          bad++;
          $display("FAIL mem_addr: got %h want %h", bus.memAddr, ea);
        end
      end
    end else if (bus.memReq) begin
      total++;
      if (addr_q.size() == 0 || bus.memAddr !== addr_q[0]) begin
        bad++;
        $display("FAIL addr_hold: got %h want %h", bus.memAddr, (addr_q.size() != 0) ? addr_q[0] : 16'hxxxx);
      end
    end
    if (bus.bufEnable && !bus.bufDendFlag) begin
      total++;
      if (dat_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_push: got enable 1 want no push");
      end else begin
        ed = dat_q.pop_front();
        if (bus.bufDats !== ed) begin
          bad++;
          $display("FAIL buf_dats: got %h want %h", bus.bufDats, ed);
        end
      end
    end
    if (bus.bufDendFlag) begin
      ends_cnt++;
      total++;
      if (bus.bufEnable !== 1'b1) begin
        bad++;
        $display("FAIL end_enable: got %b want 1", bus.bufEnable);
      end
    end
    if (bus.rowValid) begin
      valid_cycles++;
      bus.rowReady = (rv_cnt >= rdy_dly);
      rv_cnt++;
    end else begin
      bus.rowReady = 1'b0;
      rv_cnt       = 0;
    end
    if (done) done_cnt++;
  endtask

  task automatic run_row(input string name, input logic [AW-1:0] base, input logic [3:0] num,
                         input int nbeats, input int ack_d, input int rdy_d, input int hang,
                         input int exp_req, input int exp_valid, input int exp_lat, input bit mid);
    int npush, nack, lat;
    npush = (hang >= 0) ? hang + 1 : nbeats;
    nack  = (hang >= 0) ? hang : nbeats;
    ack_dly = ack_d; rdy_dly = rdy_d; hang_beat = hang;
    wait_cnt = 0; rv_cnt = 0; acks_row = 0; req_cycles = 0;
    ends_cnt = 0; valid_cycles = 0; done_cnt = 0;
    for (int i = 0; i < npush; i++) addr_q.push_back(base + AW'(i));
    baseAddr = base; beatNum = num; start = 1'b1;
    lat = 0;
    while (done_cnt == 0 && lat < 3000) begin
      tick();
      lat++;
      if (lat == 1) start = 1'b0;
      if (mid && lat == 4) begin start = 1'b1; baseAddr = 16'h5555; beatNum = 4'd1; end
      if (mid && lat == 5) begin start = 1'b0; baseAddr = base; end
    end
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL %s done_timeout: got no done want done", name); end
    if (exp_lat >= 0) begin
      total++;
      if (lat != exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    end
    total++;
    if (ends_cnt != 1) begin bad++; $display("FAIL %s end_strobes: got %0d want 1", name, ends_cnt); end
    total++;
    if (acks_row != nack) begin bad++; $display("FAIL %s beats: got %0d want %0d", name, acks_row, nack); end
    total++;
    if (req_cycles != exp_req) begin bad++; $display("FAIL %s req_cycles: got %0d want %0d", name, req_cycles, exp_req); end
    total++;
    if (valid_cycles != exp_valid) begin bad++; $display("FAIL %s valid_cycles: got %0d want %0d", name, valid_cycles, exp_valid); end
    total++;
    if (addr_q.size() != npush - nack || dat_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: got addr %0d dat %0d want %0d 0", name, addr_q.size(), dat_q.size(), npush - nack);
    end
    addr_q.delete();
    dat_q.delete();
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got done %b busy %b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, errFlag, bus.memReq, bus.bufEnable, bus.bufDendFlag, bus.rowValid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, errFlag, bus.memReq, bus.bufEnable, bus.bufDendFlag, bus.rowValid});
    end
    total++;
    if (bus.memAddr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.memAddr); end
    total++;
    if (bus.bufDats !== '0) begin bad++; $display("FAIL reset_dats: got %h want 0", bus.bufDats); end
  endtask

  task automatic test_basic();
    run_row("basic", 16'h0010, 4'd3, 3, 0, 0, -1, 3, 1, 10, 1'b0);
  endtask

  task automatic test_clamp();
    run_row("clamp0", 16'h0020, 4'd0, 8, 0, 0, -1, 8, 1, 20, 1'b0);
    run_row("clamp12", 16'h0040, 4'd12, 8, 0, 0, -1, 8, 1, 20, 1'b0);
  endtask

  task automatic test_wrap();
    run_row("wrap", 16'hFFFE, 4'd4, 4, 0, 0, -1, 4, 1, 12, 1'b0);
  endtask

  task automatic test_stall();
    run_row("stall", 16'h0300, 4'd3, 3, 5, 7, -1, 18, 8, 32, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n;
    ack_dly = 3; rdy_dly = 0; hang_beat = -1;
    wait_cnt = 0; rv_cnt = 0; acks_row = 0; req_cycles = 0; ends_cnt = 0; valid_cycles = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) addr_q.push_back(16'h0100 + AW'(i));
    baseAddr = 16'h0100; beatNum = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(acks_row == 2 && bus.memReq && !bus.memAck) && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL reset_mid_reach: got %0d beats want 2", acks_row); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, bus.memReq, bus.bufEnable, bus.bufDendFlag, bus.rowValid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid_ctrl: got %b want 000000",
               {busy, done, bus.memReq, bus.bufEnable, bus.bufDendFlag, bus.rowValid});
    end
    total++;
    if (bus.memAddr !== '0 || bus.bufDats !== '0) begin
      bad++;
      $display("FAIL reset_mid_bus: got addr %h want 0", bus.memAddr);
    end
    total++;
    if (ends_cnt != 0) begin bad++; $display("FAIL reset_mid_end: got %0d want 0", ends_cnt); end
    bus.memAck = 1'b0;
    bus.rowReady = 1'b0;
    addr_q.delete();
    dat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_row("after_reset", 16'h0200, 4'd2, 2, 0, 0, -1, 2, 1, 8, 1'b0);
  endtask

`ifdef ROWCTRL_TIMEOUT_EN
  task automatic test_timeout();
    run_row("timeout", 16'h0400, 4'd4, 0, 0, 1, 1, 21, 1, -1, 1'b0);
    total++;
    if (errFlag !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", errFlag); end
    repeat (5) tick();
    total++;
    if (errFlag !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", errFlag); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (errFlag !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", errFlag); end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    bus.memAck = 1'b0;
    bus.memDat = '0;
    bus.bufDsetFlag = 1'b1;
    bus.rowReady = 1'b0;
    ack_dly = 0; rdy_dly = 0; hang_beat = -1;
    wait_cnt = 0; rv_cnt = 0; acks_row = 0; req_cycles = 0; ends_cnt = 0; valid_cycles = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_clamp();
    test_wrap();
    test_stall();
    test_reset_mid();
`ifdef ROWCTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
